// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions: width constants, the PC1 and PC2
// selection tables (FIPS 1-based bit numbers, bit 1 = MSB), the per-round
// left-shift schedule, the scheduler state enum and helper functions for
// PC1 selection, round-shift lookup and 28-bit rotation in both directions.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // PC1: 64-bit key -> 56-bit C||D, parity bits (8,16,..,64) never selected
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC2: 56-bit C||D -> 48-bit round subkey
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-shift amount applied to reach round n (entry n-1)
    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Bits are appended MSB-first so FIPS bit 1 lands in bit 55.
    function automatic logic [2*CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [2*CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r = {r[2*CD_W-2:0], k[6'(KEY_W - PC1[i])]};
        end
        return r;
    endfunction

    // Shift amount for a round number in 1..16.
    function automatic logic [1:0] shift_at(input logic [4:0] rnd);
        return SHIFTS[4'(rnd - 5'd1)];
    endfunction

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
        logic [CD_W-1:0] r;
        case (n)
            2'd1:    r = {x[CD_W-2:0], x[CD_W-1]};
            2'd2:    r = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
        logic [CD_W-1:0] r;
        case (n)
            2'd1:    r = {x[0], x[CD_W-1:1]};
            2'd2:    r = {x[1:0], x[CD_W-1:2]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Purely combinational PC2 selection of the 48-bit round subkey from C||D.
// Ports:
//   i_cd      [55:0] C||D, FIPS bit 1 = i_cd[55]
//   o_subkey  [47:0] subkey, FIPS bit 1 = o_subkey[47]
// -----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0]   i_cd,
    output logic [SUBKEY_W-1:0] o_subkey
);

    // Select 48 bits of C||D in PC2 order, first-selected bit ends up as MSB
    always_comb begin
        o_subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            o_subkey = {o_subkey[SUBKEY_W-2:0], i_cd[6'(2*CD_W - PC2[i])]};
        end
    end

endmodule

// File: rtl/des_key_sched_dir.sv
// -----------------------------------------------------------------------------
// des_key_sched_dir
// DES key scheduler emitting the 16 round subkeys in encrypt (K1..K16) or
// decrypt (K16..K1) order over a valid/ready handshake.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   key_valid, key      64-bit key (parity bits ignored) offered this cycle
//   decrypt             1 = K16 down to K1, 0 = K1 up to K16 (sampled with key)
//   key_ready           idle, a key is accepted
//   subkey_valid        subkey/subkey_round valid
//   subkey              48-bit PC2(C,D)
//   subkey_round        round index modulo 16 (0 means round 16)
//   subkey_ready        consumer takes the subkey this cycle
//   done                one-cycle pulse after the 16th subkey is taken
// -----------------------------------------------------------------------------
module des_key_sched_dir
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [KEY_W-1:0]    key,
    input  logic                decrypt,
    output logic                key_ready,
    output logic                subkey_valid,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          subkey_round,
    input  logic                subkey_ready,
    output logic                done
);

    state_t          r_state, w_state_nxt;
    logic [CD_W-1:0] r_c, r_d, w_c_nxt, w_d_nxt;
    logic [4:0]      r_round, w_round_nxt;
    logic            r_decrypt, w_decrypt_nxt;
    logic            r_done, w_done_nxt;
    logic [2*CD_W-1:0] w_pc1;
    logic            w_last;

    // Status outputs decoded straight from the state register
    always_comb begin
        key_ready    = (r_state == IDLE);
        subkey_valid = (r_state == EMIT);
        subkey_round = r_round[3:0];
        done         = r_done;
    end

    // Next-state, C/D rotation and round counter update
    always_comb begin
        w_state_nxt   = r_state;
        w_c_nxt       = r_c;
        w_d_nxt       = r_d;
        w_round_nxt   = r_round;
        w_decrypt_nxt = r_decrypt;
        w_done_nxt    = 1'b0;
        w_pc1         = pc1(key);
        w_last        = r_decrypt ? (r_round == 5'd1) : (r_round == 5'd16);

        case (r_state)
            IDLE: begin
                if (key_valid) begin
                    w_state_nxt   = EMIT;
                    w_decrypt_nxt = decrypt;
                    if (decrypt) begin
                        // C16/D16 equal C0/D0 since the shifts sum to 28
                        w_c_nxt     = w_pc1[2*CD_W-1:CD_W];
                        w_d_nxt     = w_pc1[CD_W-1:0];
                        w_round_nxt = 5'd16;
                    end else begin
                        // Pre-rotate so the first subkey is K1 with no extra cycle
                        w_c_nxt     = rotl28(w_pc1[2*CD_W-1:CD_W], 2'd1);
                        w_d_nxt     = rotl28(w_pc1[CD_W-1:0], 2'd1);
                        w_round_nxt = 5'd1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EMIT: begin
                if (subkey_ready) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_decrypt) begin
                        // Undo the shift that produced the current round
                        w_c_nxt     = rotr28(r_c, shift_at(r_round));
                        w_d_nxt     = rotr28(r_d, shift_at(r_round));
                        w_round_nxt = r_round - 5'd1;
                    end else begin
                        w_c_nxt     = rotl28(r_c, shift_at(r_round + 5'd1));
                        w_d_nxt     = rotl28(r_d, shift_at(r_round + 5'd1));
                        w_round_nxt = r_round + 5'd1;
                    end
                end else begin
                    w_state_nxt = EMIT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers, reset has priority over any handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_c       <= '0;
            r_d       <= '0;
            r_round   <= 5'd0;
            r_decrypt <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_c       <= w_c_nxt;
            r_d       <= w_d_nxt;
            r_round   <= w_round_nxt;
            r_decrypt <= w_decrypt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    des_pc2 u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (subkey)
    );

endmodule
